// File: rtl/channel_fifo_pkg.sv
// Shared definitions for the channel FIFO and its BRAM wrapper.
// Holds the RAM port mode encoding and the depth helper used to size storage.
package channel_fifo_pkg;

    typedef enum logic {
        RAM_READ  = 1'b0,
        RAM_WRITE = 1'b1
    } ramMode_t;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 16;

    function automatic int ramDepth(input int addrBits);
        return 1 << addrBits;
    endfunction

endpackage

// File: rtl/IceRam.sv
// Single-port BRAM wrapper with a registered read port.
// A write also loads the written word into the output register (write-through).
module IceRam
    import channel_fifo_pkg::*;
#(
    parameter int addrBits = DEFAULT_ADDR_BITS,
    parameter int dataBits = DEFAULT_DATA_BITS
) (
    input  logic                clk,
    input  logic                enable,
    input  ramMode_t            readWriteMode,
    input  logic [addrBits-1:0] addr,
    input  logic [dataBits-1:0] dataIn,
    output logic [dataBits-1:0] dataOut
);

    localparam int DEPTH = ramDepth(addrBits);

    logic [dataBits-1:0] mem [DEPTH];

    // Block RAM has no reset; the output register only moves when the port is enabled.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (readWriteMode == RAM_WRITE) begin
                mem[addr] <= dataIn;
                dataOut   <= dataIn;
            end else begin
                dataOut   <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/channel_fifo.sv
// Channel FIFO: single-port BRAM storage plus a one-entry head register.
// Arbitrates the RAM port between head prefetch, producer bypass and producer writes.
module channel_fifo
    import channel_fifo_pkg::*;
#(
    parameter int addrBits = DEFAULT_ADDR_BITS,
    parameter int dataBits = DEFAULT_DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inValid,
    output logic                inReady,
    input  logic [dataBits-1:0] inData,
    output logic                outValid,
    input  logic                outReady,
    output logic [dataBits-1:0] outData,
    output logic [addrBits:0]   count
);

    localparam int                DEPTH_INT = ramDepth(addrBits);
    localparam logic [addrBits:0] DEPTH     = (addrBits+1)'(DEPTH_INT);

    logic [addrBits-1:0] wrPtr;
    logic [addrBits-1:0] rdPtr;
    logic [addrBits:0]   ramCount;
    logic                pending;
    logic [dataBits-1:0] outReg;

    logic                pop;
    logic                headFree;
    logic                ramEmpty;
    logic                ramFull;
    logic                doPrefetch;
    logic                doBypass;
    logic                doWrite;

    logic                ramEnable;
    ramMode_t            ramMode;
    logic [addrBits-1:0] ramAddr;
    logic [dataBits-1:0] ramDataOut;

    assign pop      = outValid & outReady;
    assign headFree = (!outValid | pop) & !pending;
    assign ramEmpty = (ramCount == '0);
    assign ramFull  = (ramCount == DEPTH);

    // Prefetch outranks bypass so a word never overtakes older words still in RAM.
    always_comb begin
        doPrefetch = 1'b0;
        doBypass   = 1'b0;
        doWrite    = 1'b0;
        inReady    = 1'b0;
        if (headFree && !ramEmpty) begin
            doPrefetch = 1'b1;
            inReady    = 1'b0;
        end else if (headFree && inValid) begin
            doBypass   = 1'b1;
            inReady    = 1'b1;
        end else begin
            inReady    = !ramFull;
            doWrite    = inValid && !ramFull;
        end
    end

    assign ramEnable = doPrefetch | doWrite;
    assign ramMode   = doWrite ? RAM_WRITE : RAM_READ;
    assign ramAddr   = doPrefetch ? rdPtr : wrPtr;

    IceRam #(
        .addrBits (addrBits),
        .dataBits (dataBits)
    ) ram (
        .clk           (clk),
        .enable        (ramEnable),
        .readWriteMode (ramMode),
        .addr          (ramAddr),
        .dataIn        (inData),
        .dataOut       (ramDataOut)
    );

    // Pointer and occupancy bookkeeping; prefetch and write never share a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            ramCount <= '0;
            pending  <= 1'b0;
        end else begin
            pending <= doPrefetch;
            if (doPrefetch) begin
                rdPtr    <= rdPtr + 1'b1;
                ramCount <= ramCount - 1'b1;
            end else if (doWrite) begin
                wrPtr    <= wrPtr + 1'b1;
                ramCount <= ramCount + 1'b1;
            end
        end
    end

    // The RAM output is sampled only in the landing cycle; a write after that overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outReg   <= '0;
            outValid <= 1'b0;
        end else if (pending) begin
            outReg   <= ramDataOut;
            outValid <= 1'b1;
        end else if (doBypass) begin
            outReg   <= inData;
            outValid <= 1'b1;
        end else if (pop) begin
            outValid <= 1'b0;
        end
    end

    assign outData = outReg;
    assign count   = ramCount + (addrBits+1)'(pending) + (addrBits+1)'(outValid);

endmodule

// File: tb/tb_channel_fifo.sv
// Self-checking bench for channel_fifo with a small RAM (addrBits=3).
// Accepted words go into a scoreboard queue and are compared when popped.
module tb_channel_fifo;

    localparam int AB = 3;
    localparam int DB = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [DB-1:0] inData;
    logic          outValid;
    logic          outReady;
    logic [DB-1:0] outData;
    logic [AB:0]   count;

    int            testsRun;
    int            testsFailed;
    int            cycleNo;
    logic [DB-1:0] expQ [$];

    channel_fifo #(.addrBits(AB), .dataBits(DB)) dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .count    (count)
    );

    always #5 clk = ~clk;

    // One clock: drive, observe handshakes just before the edge, sample count after it.
    task automatic step(input logic v, input logic [DB-1:0] d, input logic r,
                        output logic acc, output logic popd,
                        output logic [DB-1:0] popData, output logic [AB:0] cnt);
        inValid  = v;
        inData   = d;
        outReady = r;
        #1;
        acc     = inValid && inReady;
        popd    = outValid && outReady;
        popData = outData;
        if (acc) expQ.push_back(inData);
        @(posedge clk);
        #1;
        cnt = count;
        cycleNo++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        testsRun++;
        if (outValid !== 1'b0 || outData !== '0 || count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: outValid=%b outData=%h count=%0d, want 0/0000/0", outValid, outData, count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();
        #1;
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_inready: got %b want 1", inReady);
        end
    endtask

    task automatic test_bypass();
        logic acc, popd;
        logic [DB-1:0] pd, exp;
        logic [AB:0] cnt;
        step(1'b1, 16'h1111, 1'b0, acc, popd, pd, cnt);
        testsRun++;
        if (acc !== 1'b1 || outValid !== 1'b1 || outData !== 16'h1111 || cnt !== 4'd1) begin
            testsFailed++;
            $display("[TB] FAIL bypass_latency: acc=%b outValid=%b outData=%h count=%0d, want 1/1/1111/1", acc, outValid, outData, cnt);
        end
        step(1'b0, '0, 1'b1, acc, popd, pd, cnt);
        exp = expQ.pop_front();
        testsRun++;
        if (popd !== 1'b1 || pd !== exp || cnt !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL bypass_pop: popped=%b data=%h count=%0d, want 1/%h/0", popd, pd, cnt, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, popd;
        logic [DB-1:0] pd, exp;
        logic [AB:0] cnt;
        int lastPop, nPops;
        for (int i = 1; i <= 5; i++) step(1'b1, DB'(i), 1'b0, acc, popd, pd, cnt);
        testsRun++;
        if (cnt !== 4'd5 || outData !== 16'h0001) begin
            testsFailed++;
            $display("[TB] FAIL b2b_fill: count=%0d head=%h, want 5/0001", cnt, outData);
        end
        lastPop = 0;
        nPops   = 0;
        for (int k = 0; k < 20 && nPops < 5; k++) begin
            step(1'b0, '0, 1'b1, acc, popd, pd, cnt);
            if (popd) begin
                exp = expQ.pop_front();
                testsRun++;
                if (pd !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_order: got %h want %h", pd, exp);
                end
                if (nPops > 0) begin
                    testsRun++;
                    if (cycleNo - 1 - lastPop !== 2) begin
                        testsFailed++;
                        $display("[TB] FAIL b2b_spacing: got %0d cycles want 2", cycleNo - 1 - lastPop);
                    end
                end
                lastPop = cycleNo - 1;
                nPops++;
            end
        end
        testsRun++;
        if (nPops !== 5 || cnt !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_drain: pops=%0d count=%0d, want 5/0", nPops, cnt);
        end
    endtask

    task automatic test_full();
        logic acc, popd;
        logic [DB-1:0] pd, exp;
        logic [AB:0] cnt;
        int waited;
        for (int i = 0; i < 9; i++) step(1'b1, 16'h0100 + DB'(i), 1'b0, acc, popd, pd, cnt);
        testsRun++;
        if (cnt !== 4'd9) begin
            testsFailed++;
            $display("[TB] FAIL full_count: got %0d want 9", cnt);
        end
        step(1'b1, 16'h0A0A, 1'b0, acc, popd, pd, cnt);
        testsRun++;
        if (acc !== 1'b0 || cnt !== 4'd9) begin
            testsFailed++;
            $display("[TB] FAIL full_reject: accepted=%b count=%0d, want 0/9", acc, cnt);
        end
        waited = 0;
        acc    = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) begin
            step(1'b1, 16'h0A0A, (k == 0), acc, popd, pd, cnt);
            waited++;
            if (popd) begin
                exp = expQ.pop_front();
                testsRun++;
                if (pd !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL full_pop: got %h want %h", pd, exp);
                end
            end
        end
        testsRun++;
        if (!acc || waited > 2) begin
            testsFailed++;
            $display("[TB] FAIL full_recover: accepted=%b after %0d cycles, want 1 within 2", acc, waited);
        end
        for (int k = 0; k < 40 && expQ.size() > 0; k++) begin
            step(1'b0, '0, 1'b1, acc, popd, pd, cnt);
            if (popd) begin
                exp = expQ.pop_front();
                testsRun++;
                if (pd !== exp || cnt !== 4'(expQ.size())) begin
                    testsFailed++;
                    $display("[TB] FAIL full_drain: data=%h count=%0d, want %h/%0d", pd, cnt, exp, expQ.size());
                end
            end
        end
    endtask

    task automatic test_pop_bypass();
        logic acc, popd;
        logic [DB-1:0] pd, exp;
        logic [AB:0] cnt;
        step(1'b1, 16'hA0A0, 1'b0, acc, popd, pd, cnt);
        step(1'b1, 16'hB0B0, 1'b1, acc, popd, pd, cnt);
        exp = expQ.pop_front();
        testsRun++;
        if (!popd || pd !== exp || !acc || cnt !== 4'd1 || outData !== 16'hB0B0 || outValid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL pop_bypass: pop=%b data=%h acc=%b count=%0d head=%h, want 1/%h/1/1/b0b0", popd, pd, acc, cnt, outData, exp);
        end
        step(1'b0, '0, 1'b1, acc, popd, pd, cnt);
        exp = expQ.pop_front();
        testsRun++;
        if (pd !== exp || cnt !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL pop_bypass_drain: data=%h count=%0d, want %h/0", pd, cnt, exp);
        end
    endtask

    task automatic test_reset_pending();
        logic acc, popd;
        logic [DB-1:0] pd, exp;
        logic [AB:0] cnt;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0C00 + DB'(i), 1'b0, acc, popd, pd, cnt);
        step(1'b0, '0, 1'b1, acc, popd, pd, cnt);
        testsRun++;
        if (cnt !== 4'd4 || outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL pending_setup: count=%0d outValid=%b, want 4/0", cnt, outValid);
        end
        outReady = 1'b0;
        reset = 1'b1;
        #1;
        testsRun++;
        if (outValid !== 1'b0 || outData !== '0 || count !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_midrun: outValid=%b outData=%h count=%0d, want 0/0000/0", outValid, outData, count);
        end
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 16'hBEEF, 1'b0, acc, popd, pd, cnt);
        step(1'b0, '0, 1'b1, acc, popd, pd, cnt);
        testsRun++;
        if (!popd || pd !== 16'hBEEF || cnt !== 4'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_beef: pop=%b data=%h count=%0d, want 1/beef/0", popd, pd, cnt);
        end
        expQ.delete();
    endtask

    task automatic test_random();
        logic acc, popd;
        logic [DB-1:0] pd, exp;
        logic [AB:0] cnt;
        int sent, got, budget;
        sent   = 0;
        got    = 0;
        budget = 60000;
        while ((sent < 10000 || expQ.size() > 0) && budget > 0) begin
            step((sent < 10000) && ($urandom_range(3) != 0), DB'(sent),
                 ($urandom_range(2) != 0), acc, popd, pd, cnt);
            budget--;
            if (acc) sent++;
            if (popd) begin
                got++;
                exp = expQ.pop_front();
                testsRun++;
                if (pd !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL random_order: got %h want %h", pd, exp);
                end
            end
            testsRun++;
            if (cnt !== 4'(expQ.size())) begin
                testsFailed++;
                $display("[TB] FAIL random_count: got %0d want %0d", cnt, expQ.size());
            end
        end
        testsRun++;
        if (budget == 0 || got !== 10000) begin
            testsFailed++;
            $display("[TB] FAIL random_complete: received %0d of 10000 words, budget left %0d", got, budget);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        cycleNo     = 0;
        inValid     = 1'b0;
        inData      = '0;
        outReady    = 1'b0;
        reset       = 1'b1;
        #2;
        test_reset();
        test_bypass();
        test_back_to_back();
        test_full();
        test_pop_bypass();
        test_reset_pending();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/channel_fifo.md
# channel_fifo

Single-clock FIFO for inter-process channel buffering. Storage is one single-port BRAM accessed through the shared BRAM wrapper `IceRam`, plus a one-entry head register. The block is the client end of that RAM interface. It arbitrates the single RAM port between producer writes and head-prefetch reads, and compensates for the RAM's one-cycle registered read latency. It sits between a channel producer and consumer, with valid/ready on both sides.

## Interface
- `addrBits`, default 8: RAM address width; RAM depth is 2^addrBits.
- `dataBits`, default 16: word width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `inValid`  in  1  producer offers `inData`.
- `inReady`  out  1  FIFO accepts this cycle (combinational).
- `inData`  in  dataBits  producer word.
- `outValid`  out  1  head register holds a word (registered).
- `outReady`  in  1  consumer takes head this cycle.
- `outData`  out  dataBits  head word (registered).
- `count`  out  addrBits+1  total occupancy, RAM plus pending plus head; maximum 2^addrBits+1.

## Operation
- State:
  - `wrPtr` and `rdPtr` (addrBits wide, natural wrap).
  - `ramCount` (0..2^addrBits).
  - `pending`: a RAM read was issued last cycle.
  - `outValid` and `outReg`.
- Per-cycle signals:
  - `pop` = `outValid & outReady`.
  - `headFree` = (`!outValid | pop`) & `!pending`.
- Exactly one action owns the RAM port per cycle, in this priority:
  1. Prefetch: if `headFree` and `ramCount != 0`, read `rdPtr`. Set `pending`=1, increment `rdPtr`, decrement `ramCount`. `inReady`=0.
  2. Bypass: if `headFree`, `ramCount == 0` and `inValid`, then `outReg` ← `inData` and `outValid` ← 1. RAM is untouched. `inReady`=1.
  3. Write: else `inReady` = (`ramCount != 2^addrBits`). On `inValid & inReady`, write `inData` to `wrPtr`, increment `wrPtr`, increment `ramCount`.
- Pending landing: in the cycle after a prefetch, `outReg` ← RAM `dataOut`, `outValid` ← 1, `pending` ← 0. The RAM port is free for a producer write in that cycle. The RAM output is captured only in this cycle, because a later write also updates the wrapper's output register.
- `pop` without a refill: `outValid` ← 0.
- `count` = `ramCount` + `pending` + `outValid`, registered terms only.
- Words leave in strict FIFO order in every mix of bypass and RAM paths. Bypass occurs only when both RAM and pending are empty, so ordering holds.
- Full: `ramCount == 2^addrBits` with the head occupied and no prefetch. Then `inReady`=0, and `inValid` is ignored without error.
- Empty: `outValid`=0. `outReady` is ignored.

## Timing
- Reset (asynchronous, active-high) clears:
  - `outValid`=0, `pending`=0, `ramCount`=0, `wrPtr`=`rdPtr`=0, `count`=0.
  - `outData`=0; `outReg` is cleared.
- After reset the FIFO is empty and `inReady`=1.
- Reset mid-operation discards all contents and any in-flight read. RAM contents are left as-is and are unreachable.
- Bypass latency: word accepted in cycle N gives `outValid`=1 in N+1.
- RAM-path latency: prefetch issued in N gives the word on `outData` in N+2.
- Sustained push and pop with a non-empty RAM gives about 1 word per 2 cycles, since prefetch and write alternate on the single port.
- `inReady` depends combinationally on `outReady`. `outValid` and `outData` are pure register outputs.
- Simultaneous `pop` and bypass: the old head leaves, the new word loads, and `count` is unchanged.
- Simultaneous `pop` and prefetch: `outValid`=0 for exactly one cycle (the pending cycle).
- Pointer wrap from 2^addrBits−1 to 0 has no special handling.

## Structure
- Shared package:
  - `RAM_READ`/`RAM_WRITE` mode constants, from the existing defaults header.
  - Depth localparam 2^addrBits.
- One sub-module: `IceRam` (addrBits, dataBits). `readWriteMode` = `RAM_WRITE` only on the write action.
- All arbitration stays in `channel_fifo`. No other hierarchy.

## Test plan
- Reset, then push 0x1111 with `outReady`=0. Expect `outValid`=1 next cycle, `outData`=0x1111, `count`=1, and no RAM write.
- Push 0x0001..0x0005 back-to-back with `outReady`=0. Expect `count`=5, with the head 0x0001 via bypass and 4 words in RAM. Then hold `outReady`=1 and expect 0x0001..0x0005 in order, each RAM word 2 cycles after its prefetch.
- addrBits=3: push 9 words. Expect `inReady`=0 at `count`=9 and the 10th word not accepted. Pop one and expect `inReady` to return within 2 cycles.
- Random `inValid`/`outReady` with 10k words across pointer wraps. The scoreboard checks order, no loss or duplication, and that `count` matches the model every cycle.
- Assert `reset` in a pending cycle with `count`=4. Expect all outputs 0 immediately. A subsequent push of 0xBEEF is the next word out.
- Head valid, RAM empty, `inValid`=1 and `outReady`=1 in the same cycle. Expect the next head to be the new word with `count` unchanged.
